// File: rtl/game_tick_gen_if.sv
// game_tick_gen_if: control and status bundle between board switches/keys,
// the tick generator and the game state machine.
//   manual_step_n  raw step key, active-low, asynchronous
//   mode_select    raw switch, 1 = manual mode
//   pause          raw switch, 1 = hold auto ticks
//   rate_sel       raw switches, auto rate = base / 2^rate_sel
//   tick           one-cycle frame-advance strobe
//   frame_count    ticks issued, wraps modulo 2^FRAME_CNT_W
//   manual_active  synchronised mode_select
// master = switch/key side (drives raw inputs), slave = tick generator.
interface game_tick_gen_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   manual_step_n;
  logic                   mode_select;
  logic                   pause;
  logic [1:0]             rate_sel;
  logic                   tick;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic                   manual_active;

  modport master (
    output manual_step_n, mode_select, pause, rate_sel,
    input  tick, frame_count, manual_active
  );

  modport slave (
    input  manual_step_n, mode_select, pause, rate_sel,
    output tick, frame_count, manual_active
  );
endinterface

// File: rtl/game_tick_gen.sv
// game_tick_gen: game-frame tick generator. Emits a one-cycle enable strobe
// (not a derived clock) at CLK_HZ/TICK_HZ, optionally slowed by 2^rate_sel,
// paused with debounced frame-advance, or driven purely by the step key.
//   clk_25MHz  system clock
//   rst_n      asynchronous active-low reset
//   bus        game_tick_gen_if.slave: raw switches/key in, tick/count out
module game_tick_gen #(
  parameter int CLK_HZ          = 25000000,
  parameter int TICK_HZ         = 60,
  parameter int DIV_W           = 20,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic            clk_25MHz,
  input  logic            rst_n,
  game_tick_gen_if.slave  bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef struct packed {
    logic       key_n;
    logic       mode;
    logic       pause;
    logic [1:0] rate;
  } ctl_t;

  // ---- 2-flop synchronisers: sync_q[1] is the only copy logic may use ----
  ctl_t         raw;
  ctl_t [1:0]   sync_q;
  ctl_t         s;

  assign raw = '{key_n: bus.manual_step_n, mode: bus.mode_select,
                 pause: bus.pause, rate: bus.rate_sel};
  assign s   = sync_q[1];

  // ---- state ----
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [2:0]             pre_cnt_q, pre_cnt_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   key_db_q, key_db_d;     // 1 = released
  logic                   tick_q, tick_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic       base_strb, auto_strb, press_evt;
  logic [2:0] rate_mask;

  always_comb begin
    // Divider free-runs in every mode so the auto phase survives pause/manual.
    base_strb = (div_cnt_q == DIV_LAST);
    div_cnt_d = base_strb ? '0 : div_cnt_q + DIV_W'(1);

    // Prescaler: pass one base strobe in 2^rate; rate changes are not
    // re-aligned, they simply apply from the next base strobe.
    rate_mask = ~(3'b111 << s.rate);
    auto_strb = base_strb && ((pre_cnt_q & rate_mask) == 3'd0);
    pre_cnt_d = base_strb ? pre_cnt_q + 3'd1 : pre_cnt_q;

    // Debounce: count consecutive cycles the key disagrees with the accepted
    // level; accept the new level on the DEBOUNCE_CYCLES-th such cycle.
    deb_cnt_d = deb_cnt_q;
    key_db_d  = key_db_q;
    press_evt = 1'b0;
    if (s.key_n == key_db_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d = '0;
      key_db_d  = s.key_n;
      press_evt = ~s.key_n;            // only released->pressed counts
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end

    // Exactly one source is eligible at a time, so tick can never stretch.
    tick_d      = (s.mode || s.pause) ? press_evt : auto_strb;
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(tick_d);
  end

  // Synchronisers clear to 0 like everything else; the debounced level is
  // the one register that resets to "released".
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      div_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      key_db_q    <= 1'b1;
      tick_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sync_q      <= {sync_q[0], raw};
      div_cnt_q   <= div_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      key_db_q    <= key_db_d;
      tick_q      <= tick_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.tick          = tick_q;
  assign bus.frame_count   = frame_cnt_q;
  assign bus.manual_active = s.mode;

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: directed test-plan phases plus random switch/key
// activity, checked every cycle against a cycle-indexed reference model.
module tb_game_tick_gen;

  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DEB = 4;
  localparam int FCW = 4;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  game_tick_gen_if #(.FRAME_CNT_W(FCW)) bus ();

  game_tick_gen #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIV_W(20),
    .DEBOUNCE_CYCLES(DEB), .FRAME_CNT_W(FCW)
  ) dut (
    .clk_25MHz(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---- reference model ----
  // hist[k] = raw inputs {key,mode,pause,rate[1:0]} seen at edge k after reset.
  // A raw value sampled at edge k steers decisions from edge k+2 onwards;
  // before reset release the synchronisers read as 0.
  logic [4:0] hist [HMAX];
  int  n;          // edges since reset release
  bit  m_db;       // accepted key level, 1 = released
  int  exp_tick, exp_fc, exp_ma;
  int  tick_seen, first_tick;

  function automatic logic [4:0] raw_at(input int k);
    return (k < 1) ? 5'd0 : hist[k];
  endfunction

  task automatic model_reset();
    n = 0; m_db = 1'b1; exp_tick = 0; exp_fc = 0; exp_ma = 0;
  endtask

  task automatic model_step();
    logic [4:0] d;
    bit flip, press, base, autos;
    int pre, rate;
    n++;
    hist[n] = {bus.manual_step_n, bus.mode_select, bus.pause, bus.rate_sel};
    d = raw_at(n - 2);
    // key accepted once the last DEB decision samples all disagree with it
    flip = (n >= DEB);
    for (int i = 0; i < DEB; i++)
      if (raw_at(n - 2 - i)[4] == m_db) flip = 1'b0;
    press = flip && m_db;
    if (flip) m_db = ~m_db;
    // base strobe on every DIV-th edge; pre = base strobes already seen
    base  = ((n - 1) % DIV) == DIV - 1;
    pre   = ((n - 1) / DIV) % 8;
    rate  = int'(d[1:0]);
    autos = base && ((pre % (1 << rate)) == 0);
    exp_tick = (d[3] || d[2]) ? int'(press) : int'(autos);
    exp_fc   = (exp_fc + exp_tick) % (1 << FCW);
    exp_ma   = int'(raw_at(n - 1)[3]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("tick", int'(bus.tick), exp_tick);
    chk("frame_count", int'(bus.frame_count), exp_fc);
    chk("manual_active", int'(bus.manual_active), exp_ma);
    if (bus.tick) begin
      tick_seen++;
      if (first_tick < 0) first_tick = n;
    end
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  initial begin
    int cnt;
    bus.manual_step_n = 1'b1;
    bus.mode_select   = 1'b0;
    bus.pause         = 1'b0;
    bus.rate_sel      = 2'b00;
    model_reset();

    // ---- reset ----
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_fc", int'(bus.frame_count), 0);
    chk("rst_mact", int'(bus.manual_active), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // ---- auto full rate, first tick at 10, wrap after 16 ----
    tick_seen = 0; first_tick = -1;
    run(170);
    chk("first_tick_cycle", first_tick, 10);
    chk("auto_tick_count", tick_seen, 17);
    chk("wrap_fc", int'(bus.frame_count), 1);

    // ---- rate select: quarter, then back to full mid-run ----
    bus.rate_sel = 2'b10;
    tick_seen = 0;
    run(160);
    chk("quarter_rate_count", tick_seen, 4);
    bus.rate_sel = 2'b00;
    run(57);

    // ---- manual mode with debounce ----
    bus.mode_select = 1'b1;
    run(6);
    tick_seen = 0;
    bus.manual_step_n = 1'b0; run(3);
    bus.manual_step_n = 1'b1; run(10);
    chk("glitch_no_tick", tick_seen, 0);
    bus.manual_step_n = 1'b0;
    first_tick = -1; cnt = n;
    run(20);
    chk("press_latency", first_tick - cnt, 2 + DEB);
    run(30);
    bus.manual_step_n = 1'b1; run(40);
    chk("manual_tick_count", tick_seen, 1);

    // ---- pause with frame advance ----
    bus.mode_select = 1'b0; bus.pause = 1'b1;
    run(4);
    tick_seen = 0;
    run(100);
    chk("pause_no_tick", tick_seen, 0);
    bus.manual_step_n = 1'b0; run(12);
    bus.manual_step_n = 1'b1; run(12);
    chk("frame_advance_count", tick_seen, 1);
    bus.pause = 1'b0;
    first_tick = -1;
    run(30);
    chk("resume_phase", first_tick % DIV, 0);

    // ---- random switch/key activity ----
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0)   bus.manual_step_n = ~bus.manual_step_n;
      if ($urandom_range(149) == 0) bus.mode_select   = ~bus.mode_select;
      if ($urandom_range(99) == 0)  bus.pause         = ~bus.pause;
      if ($urandom_range(79) == 0)  bus.rate_sel      = 2'($urandom_range(3));
      cyc();
    end

    // ---- reset in the middle of a debounce ----
    bus.manual_step_n = 1'b1; bus.mode_select = 1'b1; bus.pause = 1'b0;
    run(20);
    bus.manual_step_n = 1'b0;
    run(4);                      // debounce count now at 2
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tick", int'(bus.tick), 0);
    chk("midrst_fc", int'(bus.frame_count), 0);
    chk("midrst_mact", int'(bus.manual_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick_seen = 0; first_tick = -1;
    run(3);
    chk("midrst_no_early_tick", tick_seen, 0);
    run(20);
    chk("midrst_one_press", tick_seen, 1);
    bus.manual_step_n = 1'b1;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_tick_gen.md
Name: game_tick_gen

Overview:
- Parametrised game-frame tick generator; the next generation of the 60 Hz / manual-step clock source.
- Produces a single-cycle `tick` enable in the clk_25MHz domain. It is a strobe, not a derived clock, so all game logic stays on clk_25MHz.
- Adds:
  - parametrised divider
  - selectable slow-motion rates
  - pause with frame-advance
  - debounced, edge-detected manual step
  - frame counter
- Sits between board switches/keys and the game state machine.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- TICK_HZ, 60, base tick rate in Hz. DIV = CLK_HZ/TICK_HZ (integer division, truncating; 416666 at defaults).
- DIV_W, 20, divider counter width; must satisfy 2^DIV_W > DIV.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a step-key level change (10 ms).
- FRAME_CNT_W, 16, width of frame_count.

Ports:
- clk_25MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- manual_step_n  in  1  raw push-button, active-low (0 = pressed), asynchronous.
- mode_select  in  1  raw switch; 1 = manual mode, 0 = auto mode; asynchronous.
- pause  in  1  raw switch; 1 = pause auto ticks; asynchronous.
- rate_sel  in  2  raw switches; auto rate = base/2^rate_sel (00 full, 01 half, 10 quarter, 11 eighth).
- tick  out  1  one-cycle frame-advance strobe.
- frame_count  out  FRAME_CNT_W  number of ticks issued, wraps modulo 2^FRAME_CNT_W.
- manual_active  out  1  synchronised mode_select.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers cleared: divider, prescaler, synchronisers, debounce counter, frame_count.
  - tick=0, manual_active=0.
  - debounced key state = released.
  - Reset mid-operation aborts any pending debounce or tick.
- Synchronisers:
  - manual_step_n, mode_select, pause and rate_sel each pass through a 2-flop synchroniser.
  - All control decisions use synchronised values only; input-to-effect latency is 2 cycles.
  - manual_active = synchronised mode_select.
- Divider:
  - div_cnt counts 0..DIV-1, then wraps to 0.
  - base_strb is asserted in the cycle where div_cnt == DIV-1, so its period is exactly DIV cycles.
  - Divider runs continuously in every mode, including pause and manual, so auto phase is preserved.
- Prescaler:
  - 3-bit pre_cnt increments (mod 8) on every base_strb.
  - auto_strb = base_strb AND (low rate_sel bits of pre_cnt all zero), i.e. one base strobe in every 2^rate_sel.
  - rate_sel=00 gives auto_strb = base_strb.
  - A rate change takes effect at the next base_strb; no reset of pre_cnt.
- Debounce:
  - deb_cnt resets to 0 whenever the synchronised key equals the debounced state.
  - Otherwise deb_cnt increments; when it reaches DEBOUNCE_CYCLES-1 the debounced state flips and deb_cnt clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
  - press_evt = one-cycle pulse on the debounced released→pressed transition. Holding the key gives exactly one event; release gives none.
- Tick selection (registered; tick asserts the cycle after the qualifying strobe/event):
  - manual_active=1: tick on press_evt only; auto_strb ignored.
  - manual_active=0, pause=0: tick on auto_strb only; press_evt ignored.
  - manual_active=0, pause=1: auto_strb suppressed; press_evt produces one tick (frame advance).
  - If press_evt and auto_strb coincide in a mode where both would be eligible (none currently), a single tick is issued; tick is never wider than 1 cycle.
  - Mode/pause switching never generates a spurious tick. A transition only changes which source is eligible from the next cycle.
- frame_count increments by 1 in the same cycle tick is asserted; FRAME_CNT_W wraps silently from all-ones to 0.

Test Plan:
- Use bench parameters CLK_HZ=1000, TICK_HZ=100 (DIV=10), DEBOUNCE_CYCLES=4, FRAME_CNT_W=4.
- Auto full rate: release reset, mode=0, pause=0, rate_sel=00 → first tick at cycle 10 after reset release; thereafter exactly every 10 cycles, each 1 cycle wide; frame_count 1,2,3…
- Rate select: rate_sel=10 → tick every 40 cycles. Switch to 00 mid-run → 10-cycle spacing from the next base_strb, no double tick.
- Wrap: run 16 ticks → frame_count goes F→0 on the 16th tick.
- Manual debounce: mode=1. Key low for 3 cycles then high → no tick. Key low for 20 cycles → exactly one tick about 2+4+1 cycles after the falling edge. Further holding and release → no tick. Auto strobes during this → no ticks.
- Pause/frame advance: mode=0, pause=1 for 100 cycles → zero ticks. One debounced press → one tick, frame_count +1. pause=0 → ticks resume on the divider's original phase.
- Reset mid-debounce: assert rst_n=0 while deb_cnt=2 → tick=0, frame_count=0 immediately. After release, a press needs the full 4 stable cycles.
